// File: rtl/relin_result_collector_pkg.sv
// Shared types and default sizing for the relinearisation result collector.
package relin_result_collector_pkg;

  localparam int unsigned BIT_WIDTH      = 5;
  localparam int unsigned TILE_N         = 2;
  localparam int unsigned DEGREE_N       = 8;
  localparam int unsigned Q_MOD          = 17;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } coll_state_e;

  // Index width that stays at least one bit for degenerate single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relin_result_collector_if.sv
// Tile stream bundle: relin c0/c1 tiles in, mod-Q sum tiles out to writeback.
interface relin_result_collector_if #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned TILE_WIDTH = 2,
  parameter int unsigned IDX_W      = 2
);
  logic                                  valid_i;
  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] c0_coeff_i;
  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] c1_coeff_i;
  logic                                  ready_o;
  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] c0_coeff_o;
  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] c1_coeff_o;
  logic [IDX_W-1:0]                      tile_idx_o;
  logic                                  valid_o;
  logic                                  ready_i;

  modport slave (
    input  valid_i, c0_coeff_i, c1_coeff_i, ready_i,
    output ready_o, c0_coeff_o, c1_coeff_o, tile_idx_o, valid_o
  );

  modport master (
    output valid_i, c0_coeff_i, c1_coeff_i, ready_i,
    input  ready_o, c0_coeff_o, c1_coeff_o, tile_idx_o, valid_o
  );
endinterface

// File: rtl/relin_result_collector_mod_add_tile.sv
// Combinational TILE_WIDTH-lane modular adder; both operands are already below MOD_VALUE.
module relin_result_collector_mod_add_tile #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned TILE_WIDTH = 2,
  parameter int unsigned MOD_VALUE  = 17
) (
  input  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] a_i,
  input  logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] b_i,
  output logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] sum_o
);
  localparam logic [DATA_WIDTH:0] MODQ = (DATA_WIDTH+1)'(MOD_VALUE);

  logic [TILE_WIDTH-1:0][DATA_WIDTH:0] raw;

  always_comb begin
    raw   = '0;
    sum_o = '0;
    for (int unsigned j = 0; j < TILE_WIDTH; j++) begin
      raw[j]   = {1'b0, a_i[j]} + {1'b0, b_i[j]};
      sum_o[j] = (raw[j] >= MODQ) ? DATA_WIDTH'(raw[j] - MODQ) : raw[j][DATA_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/relin_result_collector.sv
// Adds relinearised c0/c1 tiles to the base ciphertext mod Q, buffers the sums
// in a small tile FIFO and pulses done_o once a whole ciphertext has drained.
module relin_result_collector
  import relin_result_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BIT_WIDTH,
  parameter int unsigned TILE_WIDTH = TILE_N,
  parameter int unsigned DEGREE     = DEGREE_N,
  parameter int unsigned MOD_VALUE  = Q_MOD,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [1:0][DEGREE-1:0][DATA_WIDTH-1:0] base_ct_i,
  relin_result_collector_if.slave              bus,
  output logic                                 done_o,
  output logic                                 overflow_o
);
  localparam int unsigned NUM_TILES = DEGREE / TILE_WIDTH;
  localparam int unsigned IDX_W     = idx_width(NUM_TILES);
  localparam int unsigned PTR_W     = idx_width(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

  typedef logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_t;
  typedef tile_t [NUM_TILES-1:0]                 poly_t;
  typedef struct packed {
    tile_t            c0;
    tile_t            c1;
    logic [IDX_W-1:0] idx;
  } entry_t;

  coll_state_e      state_q, state_d;
  logic [IDX_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             stg_vld_q;
  entry_t           stg_q, stg_d;
  entry_t           fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q;

  poly_t  base0, base1;
  tile_t  sum0, sum1;
  entry_t head;
  logic   accept, last_tile, empty, full, pop, push, drop, drain_empty;

  // View each base polynomial as an array of tiles so the rx counter selects directly.
  assign base0 = base_ct_i[0];
  assign base1 = base_ct_i[1];

  relin_result_collector_mod_add_tile #(
    .DATA_WIDTH(DATA_WIDTH), .TILE_WIDTH(TILE_WIDTH), .MOD_VALUE(MOD_VALUE)
  ) u_add_c0 (
    .a_i(base0[rx_cnt_q]), .b_i(bus.c0_coeff_i), .sum_o(sum0)
  );

  relin_result_collector_mod_add_tile #(
    .DATA_WIDTH(DATA_WIDTH), .TILE_WIDTH(TILE_WIDTH), .MOD_VALUE(MOD_VALUE)
  ) u_add_c1 (
    .a_i(base1[rx_cnt_q]), .b_i(bus.c1_coeff_i), .sum_o(sum1)
  );

  assign accept    = (state_q == COLLECT) && bus.valid_i;
  assign last_tile = (rx_cnt_q == IDX_W'(NUM_TILES - 1));
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = !empty && bus.ready_i;
  assign push      = stg_vld_q && (!full || pop);
  assign drop      = stg_vld_q && full && !pop;
  // Leave DRAIN in the cycle the last entry pops so done_o lands one cycle later.
  assign drain_empty = !stg_vld_q && (empty || ((count_q == CNT_W'(1)) && pop));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)               state_d = COLLECT;
      COLLECT: if (accept && last_tile)   state_d = DRAIN;
      DRAIN:   if (drain_empty)           state_d = DONE;
      DONE:                               state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = (state_q == COLLECT) && !full;
    done_o      = (state_q == DONE);
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if ((state_q == IDLE) && start_i) rx_cnt_d = '0;
    else if (accept)                  rx_cnt_d = rx_cnt_q + IDX_W'(1);

    stg_d = stg_q;
    if (accept) stg_d = '{c0: sum0, c1: sum1, idx: rx_cnt_q};

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q  <= '0;
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rx_cnt_q  <= rx_cnt_d;
      stg_vld_q <= accept;
      stg_q     <= stg_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (drop) ovf_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= stg_q;
  end

  // Outputs read zero whenever nothing is buffered, including straight after reset.
  assign head           = empty ? '0 : fifo_q[rd_ptr_q];
  assign bus.valid_o    = !empty;
  assign bus.c0_coeff_o = head.c0;
  assign bus.c1_coeff_o = head.c1;
  assign bus.tile_idx_o = head.idx;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_relin_result_collector.sv
// Two collectors (4-tile and 5-tile polynomials) share one stimulus stream and are
// checked every cycle against a queue-based behavioural model.
module tb_relin_result_collector;
  localparam int unsigned DW = 5, TW = 2, Q = 17, DEPTH = 4;

  typedef struct packed {
    logic [1:0][4:0] c0;
    logic [1:0][4:0] c1;
    logic [2:0]      idx;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0, rdy = 1'b0;
  logic [1:0][4:0] c0_in = '0, c1_in = '0;
  logic [1:0][9:0][4:0] base_b = '0;
  logic [1:0][7:0][4:0] base_a;
  logic done_a, done_b, ovf_a, ovf_b;

  assign base_a = {base_b[1][7:0], base_b[0][7:0]};

  relin_result_collector_if #(.DATA_WIDTH(DW), .TILE_WIDTH(TW), .IDX_W(2)) ifa ();
  relin_result_collector_if #(.DATA_WIDTH(DW), .TILE_WIDTH(TW), .IDX_W(3)) ifb ();

  assign ifa.valid_i = valid;  assign ifb.valid_i = valid;
  assign ifa.c0_coeff_i = c0_in; assign ifb.c0_coeff_i = c0_in;
  assign ifa.c1_coeff_i = c1_in; assign ifb.c1_coeff_i = c1_in;
  assign ifa.ready_i = rdy;    assign ifb.ready_i = rdy;

  relin_result_collector #(.DATA_WIDTH(DW), .TILE_WIDTH(TW), .DEGREE(8), .MOD_VALUE(Q),
                           .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .start_i(start), .base_ct_i(base_a), .bus(ifa.slave),
    .done_o(done_a), .overflow_o(ovf_a));

  relin_result_collector #(.DATA_WIDTH(DW), .TILE_WIDTH(TW), .DEGREE(10), .MOD_VALUE(Q),
                           .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .start_i(start), .base_ct_i(base_b), .bus(ifb.slave),
    .done_o(done_b), .overflow_o(ovf_b));

  always #5 clk = ~clk;

  exp_t mq [2][$];
  exp_t stg [2];
  bit   coll [2], drn [2], dn [2], ovf [2], sv [2];
  int   rx [2];
  bit   model_ok = 1'b0;
  int   errors = 0, checks = 0, lit_mode = 0;

  function automatic int ntiles(input int i);
    return (i == 0) ? 4 : 5;
  endfunction

  function automatic exp_t mk(input int k);
    exp_t t;
    for (int j = 0; j < 2; j++) begin
      t.c0[j] = 5'((int'(base_b[0][k*2+j]) + int'(c0_in[j])) % Q);
      t.c1[j] = 5'((int'(base_b[1][k*2+j]) + int'(c1_in[j])) % Q);
    end
    t.idx = 3'(k);
    return t;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic compare();
    exp_t h, e;
    logic r, v, d, o;
    if (!model_ok) return;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        r = ifa.ready_o; v = ifa.valid_o; d = done_a; o = ovf_a;
        h.c0 = ifa.c0_coeff_o; h.c1 = ifa.c1_coeff_o; h.idx = {1'b0, ifa.tile_idx_o};
      end else begin
        r = ifb.ready_o; v = ifb.valid_o; d = done_b; o = ovf_b;
        h.c0 = ifb.c0_coeff_o; h.c1 = ifb.c1_coeff_o; h.idx = ifb.tile_idx_o;
      end
      chk("ready_o", i, 32'(r), 32'(coll[i] && (mq[i].size() < DEPTH)));
      chk("valid_o", i, 32'(v), 32'(mq[i].size() > 0));
      chk("done_o", i, 32'(d), 32'(dn[i]));
      chk("overflow_o", i, 32'(o), 32'(ovf[i]));
      if (mq[i].size() > 0) begin
        e = mq[i][0];
        chk("c0_tile", i, 32'(h.c0), 32'(e.c0));
        chk("c1_tile", i, 32'(h.c1), 32'(e.c1));
        chk("tile_idx", i, 32'(h.idx), 32'(e.idx));
        if (lit_mode == 1)
          for (int j = 0; j < 2; j++) begin
            chk("lit_all4_c0", i, 32'(h.c0[j]), 32'd4);
            chk("lit_all4_c1", i, 32'(h.c1[j]), 32'd4);
          end
        if (lit_mode == 2) begin
          chk("lit_bnd_c0_l0", i, 32'(h.c0[0]), 32'd0);
          chk("lit_bnd_c0_l1", i, 32'(h.c0[1]), 32'd16);
          chk("lit_bnd_c1_l0", i, 32'(h.c1[0]), 32'd0);
          chk("lit_bnd_c1_l1", i, 32'(h.c1[1]), 32'd16);
        end
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mq[i].delete();
        coll[i] = 0; drn[i] = 0; dn[i] = 0; ovf[i] = 0; sv[i] = 0; rx[i] = 0;
      end else begin
        bit idle, acc, fin;
        idle = !coll[i] && !drn[i] && !dn[i];
        acc  = coll[i] && valid;
        if ((mq[i].size() > 0) && rdy) void'(mq[i].pop_front());
        if (sv[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(stg[i]);
          else ovf[i] = 1;
        end
        fin = drn[i] && !sv[i] && (mq[i].size() == 0);
        if (fin) drn[i] = 0;
        dn[i] = fin;
        sv[i] = acc;
        if (acc) begin
          stg[i] = mk(rx[i]);
          rx[i]++;
          if (rx[i] == ntiles(i)) begin coll[i] = 0; drn[i] = 1; end
        end
        if (idle && start) begin coll[i] = 1; rx[i] = 0; end
      end
    end
    if (rst) model_ok = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic rand_tile();
    for (int j = 0; j < 2; j++) begin
      c0_in[j] = 5'($urandom_range(0, 16));
      c1_in[j] = 5'($urandom_range(0, 16));
    end
  endtask

  task automatic rand_base();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 10; k++) base_b[p][k] = 5'($urandom_range(0, 16));
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((coll[0] || drn[0] || dn[0] || coll[1] || drn[1] || dn[1]) && (c < budget)) begin
      step(); c++;
    end
    checks++;
    if (c >= budget) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", c);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; step(); step(); rst = 1'b0; step();
    chk("rst_c0_o", 0, 32'(ifa.c0_coeff_o), 32'd0);
    chk("rst_idx_o", 0, 32'(ifa.tile_idx_o), 32'd0);
    chk("rst_valid_o", 1, 32'(ifb.valid_o), 32'd0);
    chk("rst_ready_o", 1, 32'(ifb.ready_o), 32'd0);

    // all-16 base plus all-5 inputs wraps to 4 everywhere
    for (int p = 0; p < 2; p++) for (int k = 0; k < 10; k++) base_b[p][k] = 5'd16;
    lit_mode = 1; rdy = 1'b1;
    do_start();
    c0_in = {5'd5, 5'd5}; c1_in = {5'd5, 5'd5};
    valid = 1'b1; for (int t = 0; t < 5; t++) step(); valid = 1'b0;
    wait_idle(60);
    lit_mode = 0;

    // boundary lanes: 0+0, 16+0, 16+1, 8+8
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 10; k++)
        case (k % 4) 0: base_b[p][k] = 5'd0; 1: base_b[p][k] = 5'd16;
                     2: base_b[p][k] = 5'd16; default: base_b[p][k] = 5'd8; endcase
    lit_mode = 2;
    do_start();
    for (int t = 0; t < 5; t++) begin
      c0_in = (t % 2 == 1) ? {5'd8, 5'd1} : {5'd0, 5'd0};
      c1_in = c0_in;
      valid = 1'b1; step();
    end
    valid = 1'b0;
    wait_idle(60);
    lit_mode = 0;

    // backpressure: 4-tile unit fills exactly, 5-tile unit drops its last tile
    rand_base(); rdy = 1'b0;
    do_start();
    for (int t = 0; t < 5; t++) begin rand_tile(); valid = 1'b1; step(); end
    valid = 1'b0;
    for (int t = 0; t < 4; t++) step();
    chk("full_no_ovf", 0, 32'(ovf_a), 32'd0);
    chk("drop_ovf", 1, 32'(ovf_b), 32'd1);
    chk("full_valid", 0, 32'(ifa.valid_o), 32'd1);
    rdy = 1'b1;
    wait_idle(60);
    chk("ovf_sticky", 1, 32'(ovf_b), 32'd1);

    // valid in IDLE and start in COLLECT are ignored
    rand_tile(); valid = 1'b1; step(); step(); step(); valid = 1'b0;
    do_start();
    for (int t = 0; t < 2; t++) begin rand_tile(); valid = 1'b1; step(); end
    start = 1'b1; rand_tile(); step(); start = 1'b0;
    for (int t = 0; t < 3; t++) begin rand_tile(); step(); end
    valid = 1'b0;
    wait_idle(60);

    // reset mid-collection, then a clean run
    do_start();
    for (int t = 0; t < 2; t++) begin rand_tile(); valid = 1'b1; step(); end
    valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_valid", 0, 32'(ifa.valid_o), 32'd0);
    chk("rst_mid_ready", 1, 32'(ifb.ready_o), 32'd0);
    chk("rst_mid_ovf", 1, 32'(ovf_b), 32'd0);
    do_start();
    for (int t = 0; t < 5; t++) begin rand_tile(); valid = 1'b1; step(); end
    valid = 1'b0;
    wait_idle(60);

    // randomized runs with gaps on valid and random downstream stalls
    for (int run = 0; run < 8; run++) begin
      rand_base();
      do_start();
      for (int c = 0; (c < 200) && (coll[0] || coll[1]); c++) begin
        rand_tile();
        valid = ($urandom_range(0, 3) != 0);
        rdy   = ($urandom_range(0, 3) != 0);
        step();
      end
      valid = 1'b0;
      rdy = 1'b1;
      wait_idle(100);
      if (run == 3) begin rst = 1'b1; step(); rst = 1'b0; end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
